// File: rtl/jtag_tap_target_pkg.sv
// Shared JTAG definitions: TAP state encodings (common to master and target),
// default opcodes, and the TAP next-state function.
package jtag_tap_target_pkg;

  typedef enum logic [3:0] {
    TAP_EXIT2_DR   = 4'h0,
    TAP_EXIT1_DR   = 4'h1,
    TAP_SHIFT_DR   = 4'h2,
    TAP_PAUSE_DR   = 4'h3,
    TAP_SELECT_IR  = 4'h4,
    TAP_UPDATE_DR  = 4'h5,
    TAP_CAPTURE_DR = 4'h6,
    TAP_SELECT_DR  = 4'h7,
    TAP_EXIT2_IR   = 4'h8,
    TAP_EXIT1_IR   = 4'h9,
    TAP_SHIFT_IR   = 4'hA,
    TAP_PAUSE_IR   = 4'hB,
    TAP_RTI        = 4'hC,
    TAP_UPDATE_IR  = 4'hD,
    TAP_CAPTURE_IR = 4'hE,
    TAP_TLR        = 4'hF
  } tap_state_t;

  typedef enum logic [1:0] {
    DR_BYPASS,
    DR_IDCODE,
    DR_USER
  } dr_sel_t;

  localparam int          IR_LEN_DEF       = 10;
  localparam int          USER_LEN_DEF     = 32;
  localparam logic [31:0] IDCODE_VAL_DEF   = 32'h1000_0E7F;
  localparam logic [9:0]  INSTR_IDCODE_DEF = 10'h003;
  localparam logic [9:0]  INSTR_USER_DEF   = 10'h302;
  localparam logic [9:0]  INSTR_BYPASS_DEF = 10'h3FF;

  function automatic tap_state_t tap_next(input tap_state_t s, input logic tms);
    case (s)
      TAP_TLR:        return tms ? TAP_TLR       : TAP_RTI;
      TAP_RTI:        return tms ? TAP_SELECT_DR : TAP_RTI;
      TAP_SELECT_DR:  return tms ? TAP_SELECT_IR : TAP_CAPTURE_DR;
      TAP_CAPTURE_DR: return tms ? TAP_EXIT1_DR  : TAP_SHIFT_DR;
      TAP_SHIFT_DR:   return tms ? TAP_EXIT1_DR  : TAP_SHIFT_DR;
      TAP_EXIT1_DR:   return tms ? TAP_UPDATE_DR : TAP_PAUSE_DR;
      TAP_PAUSE_DR:   return tms ? TAP_EXIT2_DR  : TAP_PAUSE_DR;
      TAP_EXIT2_DR:   return tms ? TAP_UPDATE_DR : TAP_SHIFT_DR;
      TAP_UPDATE_DR:  return tms ? TAP_SELECT_DR : TAP_RTI;
      TAP_SELECT_IR:  return tms ? TAP_TLR       : TAP_CAPTURE_IR;
      TAP_CAPTURE_IR: return tms ? TAP_EXIT1_IR  : TAP_SHIFT_IR;
      TAP_SHIFT_IR:   return tms ? TAP_EXIT1_IR  : TAP_SHIFT_IR;
      TAP_EXIT1_IR:   return tms ? TAP_UPDATE_IR : TAP_PAUSE_IR;
      TAP_PAUSE_IR:   return tms ? TAP_EXIT2_IR  : TAP_PAUSE_IR;
      TAP_EXIT2_IR:   return tms ? TAP_UPDATE_IR : TAP_SHIFT_IR;
      TAP_UPDATE_IR:  return tms ? TAP_SELECT_DR : TAP_RTI;
      default:        return TAP_TLR;
    endcase
  endfunction

endpackage

// File: rtl/jtag_tap_target_pin_sync.sv
// Brings the JTAG pins into the clk domain and derives single-clk TCK edge pulses.
// With JTAG_TAP_TARGET_TRST_EN defined, also synchronises trst_n.
module jtag_pin_sync (
  input  logic clk,
  input  logic rst,
  input  logic tck,
  input  logic tms,
  input  logic tdi,
`ifdef JTAG_TAP_TARGET_TRST_EN
  input  logic trst_n,
  output logic trst_sync_n,
`endif
  output logic tck_rise,
  output logic tck_fall,
  output logic tms_sync,
  output logic tdi_sync
);

  logic [2:0] tck_q;
  logic [1:0] tms_q;
  logic [1:0] tdi_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      tck_q <= '0;
      tms_q <= '0;
      tdi_q <= '0;
    end else begin
      tck_q <= {tck_q[1:0], tck};
      tms_q <= {tms_q[0], tms};
      tdi_q <= {tdi_q[0], tdi};
    end
  end

  // tms/tdi come from the same stage as tck_q[1] so they line up with tck_rise
  assign tck_rise = tck_q[1] & ~tck_q[2];
  assign tck_fall = ~tck_q[1] & tck_q[2];
  assign tms_sync = tms_q[1];
  assign tdi_sync = tdi_q[1];

`ifdef JTAG_TAP_TARGET_TRST_EN
  logic [1:0] trst_q;

  always_ff @(posedge clk) begin
    if (rst) trst_q <= '0;
    else     trst_q <= {trst_q[0], trst_n};
  end

  assign trst_sync_n = trst_q[1];
`endif

endmodule

// File: rtl/jtag_tap_target.sv
// JTAG TAP responder with IR, BYPASS, IDCODE and one USER data register.
// Optional test-reset pin enabled by defining JTAG_TAP_TARGET_TRST_EN.
module jtag_tap_target
  import jtag_tap_target_pkg::*;
#(
  parameter int                IR_LEN       = IR_LEN_DEF,
  parameter logic [31:0]       IDCODE_VAL   = IDCODE_VAL_DEF,
  parameter logic [IR_LEN-1:0] INSTR_IDCODE = INSTR_IDCODE_DEF,
  parameter logic [IR_LEN-1:0] INSTR_USER   = INSTR_USER_DEF,
  parameter int                USER_LEN     = USER_LEN_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                tck,
  input  logic                tms,
  input  logic                tdi,
`ifdef JTAG_TAP_TARGET_TRST_EN
  input  logic                trst_n,
`endif
  output logic                tdo,
  output logic                tdo_oe,
  output logic [3:0]          tap_state,
  output logic [IR_LEN-1:0]   ir_value,
  input  logic [USER_LEN-1:0] user_dr_in,
  output logic [USER_LEN-1:0] user_dr_out,
  output logic                user_dr_update
);

  logic tck_rise, tck_fall, tms_sync, tdi_sync, trst_active;

  jtag_pin_sync u_sync (
    .clk         (clk),
    .rst         (rst),
    .tck         (tck),
    .tms         (tms),
    .tdi         (tdi),
`ifdef JTAG_TAP_TARGET_TRST_EN
    .trst_n      (trst_n),
    .trst_sync_n (trst_sync_n),
`endif
    .tck_rise    (tck_rise),
    .tck_fall    (tck_fall),
    .tms_sync    (tms_sync),
    .tdi_sync    (tdi_sync)
  );

`ifdef JTAG_TAP_TARGET_TRST_EN
  logic trst_sync_n;
  assign trst_active = ~trst_sync_n;
`else
  assign trst_active = 1'b0;
`endif

  tap_state_t          state_q, state_d;
  dr_sel_t             dr_sel;
  logic                in_shift, shift_lsb;
  logic [IR_LEN-1:0]   ir_shift;
  logic [31:0]         id_shift;
  logic [USER_LEN-1:0] usr_shift;
  logic                bypass_q;

  always_ff @(posedge clk) begin
    if (rst || trst_active) state_q <= TAP_TLR;
    else if (tck_rise)      state_q <= state_d;
  end

  always_comb state_d = tap_next(state_q, tms_sync);

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    dr_sel    = DR_BYPASS;
    in_shift  = 1'b0;
    shift_lsb = 1'b0;
    if (ir_value == INSTR_IDCODE)    dr_sel = DR_IDCODE;
    else if (ir_value == INSTR_USER) dr_sel = DR_USER;
    case (state_q)
      TAP_SHIFT_IR: begin
        in_shift  = 1'b1;
        shift_lsb = ir_shift[0];
      end
      TAP_SHIFT_DR: begin
        in_shift = 1'b1;
        case (dr_sel)
          DR_IDCODE: shift_lsb = id_shift[0];
          DR_USER:   shift_lsb = usr_shift[0];
          default:   shift_lsb = bypass_q;
        endcase
      end
      default: ;
    endcase
  end

  assign tap_state = state_q;

  // NOTE: shift registers are reset explicitly so a reset mid-shift discards partial data.
  always_ff @(posedge clk) begin
    user_dr_update <= 1'b0;
    if (rst) begin
      ir_shift    <= '0;
      id_shift    <= '0;
      usr_shift   <= '0;
      bypass_q    <= 1'b0;
      ir_value    <= INSTR_IDCODE;
      user_dr_out <= '0;
      tdo         <= 1'b0;
      tdo_oe      <= 1'b0;
    end else if (trst_active) begin
      ir_value <= INSTR_IDCODE;
      tdo      <= 1'b0;
      tdo_oe   <= 1'b0;
    end else if (tck_rise) begin
      case (state_q)
        TAP_CAPTURE_IR: ir_shift <= {{(IR_LEN-2){1'b0}}, 2'b01};
        TAP_SHIFT_IR:   ir_shift <= {tdi_sync, ir_shift[IR_LEN-1:1]};
        TAP_UPDATE_IR:  ir_value <= ir_shift;
        TAP_CAPTURE_DR: begin
          case (dr_sel)
            DR_IDCODE: id_shift  <= IDCODE_VAL;
            DR_USER:   usr_shift <= user_dr_in;
            default:   bypass_q  <= 1'b0;
          endcase
        end
        TAP_SHIFT_DR: begin
          case (dr_sel)
            DR_IDCODE: id_shift  <= {tdi_sync, id_shift[31:1]};
            DR_USER:   usr_shift <= {tdi_sync, usr_shift[USER_LEN-1:1]};
            default:   bypass_q  <= tdi_sync;
          endcase
        end
        TAP_UPDATE_DR: begin
          if (dr_sel == DR_USER) begin
            user_dr_out    <= usr_shift;
            user_dr_update <= 1'b1;
          end
        end
        default: ;
      endcase
      // UPDATE_IR never leads to TLR, so this cannot collide with the IR load above
      if (state_d == TAP_TLR) ir_value <= INSTR_IDCODE;
    end else if (tck_fall) begin
      tdo    <= in_shift & shift_lsb;
      tdo_oe <= in_shift;
    end
  end

endmodule
